// File: rtl/reg_read_pkg.sv
// Shared types and constants for the register-bank read controller.
package reg_read_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int DEF_WIDTH = 10;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-port round-robin arbiter; the priority pointer flips away from each winner.
module rr_arbiter_2
  import reg_read_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic en,
  output logic gnt_a,
  output logic gnt_b,
  output logic winner
);

  // Port currently preferred when both request.
  logic ptr;

  // A lone requester always wins; on contention the pointer decides.
  always_comb begin
    gnt_a  = en & req_a & (~req_b | (ptr == PORT_A));
    gnt_b  = en & req_b & (~req_a | (ptr == PORT_B));
    winner = gnt_b ? PORT_B : PORT_A;
  end

  // After any grant, prefer the port that did not just win.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= PORT_A;
    end else if (gnt_a | gnt_b) begin
      ptr <= (winner == PORT_A) ? PORT_B : PORT_A;
    end
  end

endmodule

// File: rtl/reg_read_ctrl.sv
// Read-side controller for a bank of registers: arbitrates two read clients,
// selects the addressed register, and returns its word on a valid/ready channel.
module reg_read_ctrl
  import reg_read_pkg::*;
#(
  parameter int NREG  = 8,
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic [AW-1:0]         a_addr,
  output logic                  a_gnt,
  input  logic                  b_req,
  input  logic [AW-1:0]         b_addr,
  output logic                  b_gnt,
  input  logic [NREG*WIDTH-1:0] reg_data,
  output logic [NREG-1:0]       chosen,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_port,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  err
);

  // Extra bit so the range check also works when NREG == 2**AW.
  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  state_t           state;
  logic [AW-1:0]    addr_reg;
  logic             port_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic             err_reg;
  logic             rsp_valid_reg;

  logic             arb_en;
  logic             winner;
  logic             in_range;
  logic [WIDTH-1:0] sel_data;

  // Grants only in IDLE, and never while reset is held.
  assign arb_en = (state == IDLE) & rst;

  rr_arbiter_2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_a  (a_req),
    .req_b  (b_req),
    .en     (arb_en),
    .gnt_a  (a_gnt),
    .gnt_b  (b_gnt),
    .winner (winner)
  );

  assign in_range = ({1'b0, addr_reg} < NREG_W);

  // One-hot select into the bank, driven only during SEL.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_chosen
      assign chosen[gi] = (state == SEL) && (addr_reg == AW'(gi));
    end
  endgenerate

  // Pick the addressed slice; out-of-range addresses fall through to zero.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREG; i++) begin
      if (addr_reg == AW'(i)) begin
        sel_data = reg_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Main FSM: latch the winner in IDLE, capture data in SEL, hold in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      addr_reg      <= '0;
      port_reg      <= PORT_A;
      rsp_data_reg  <= '0;
      err_reg       <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a_gnt | b_gnt) begin
            addr_reg <= (winner == PORT_B) ? b_addr : a_addr;
            port_reg <= winner;
            state    <= SEL;
          end
        end
        SEL: begin
          // Bank registers update on this same edge, so the pre-write value is taken.
          rsp_data_reg  <= in_range ? sel_data : '0;
          err_reg       <= ~in_range;
          rsp_valid_reg <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_port  = port_reg;
  assign err       = err_reg;

endmodule

// File: doc/reg_read_ctrl.md
# reg_read_ctrl

Read-side controller for the bank of 10-bit registers (one `register_10b` per entry). It complements the write path, which drives `chosen`/`w_en`/`w_data`. Two clients issue read requests by address; the controller arbitrates between them round-robin, drives the one-hot `chosen` select into the bank and samples the addressed `r_data`. It then returns the word on a valid/ready response channel tagged with the requesting port.

## Interface
- `NREG`, default 8: number of registers in the bank; must be ≥ 2.
- `WIDTH`, default 10: data width per register.
- `AW`, default 3: address width; must satisfy 2^AW ≥ NREG.
- Clocking: one clock; reset is asynchronous and active-low (`rst`).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asserted when low.
- `a_req`  in  1  port A read request; held until `a_gnt`.
- `a_addr`  in  AW  port A register address; stable while `a_req` is high.
- `a_gnt`  out  1  port A request accepted this cycle.
- `b_req`  in  1  port B read request.
- `b_addr`  in  AW  port B register address.
- `b_gnt`  out  1  port B request accepted this cycle.
- `reg_data`  in  NREG*WIDTH  flattened bank outputs; register i occupies `[i*WIDTH +: WIDTH]`.
- `chosen`  out  NREG  one-hot register select into the bank.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_port`  out  1  requesting port of the response: 0 = A, 1 = B.
- `rsp_data`  out  WIDTH  read data.
- `err`  out  1  response is for an out-of-range address; qualified by `rsp_valid`.

## Operation
- FSM has three states: IDLE, SEL and RESP.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - If any request is pending, grant one (`x_gnt` = 1, combinational, this cycle only), latch its address and port, and go to SEL.
- **SEL**
  - `chosen` = one-hot of the latched address; all-zero if the address is ≥ NREG.
  - At the clock edge, capture the addressed slice of `reg_data` into `rsp_data`.
  - For an out-of-range address, capture 0 and set `err`.
  - Go to RESP.
- **RESP**
  - `rsp_valid` = 1; `rsp_data`, `rsp_port` and `err` are held stable.
  - When `rsp_ready` = 1, go to IDLE.
  - There is no grant in RESP; new requests wait.
- **Arbitration**
  - A priority pointer selects the preferred port; reset value is A.
  - A single requester is always granted.
  - If both ports request, the pointer's port wins; after any grant, the pointer moves to the other port.
- **Outputs outside their state**
  - `chosen` = 0 outside SEL.
  - `a_gnt` and `b_gnt` = 0 outside IDLE.
- **Reset**, immediate including mid-operation:
  - State returns to IDLE and the pointer to A.
  - `chosen`, `a_gnt`, `b_gnt`, `rsp_valid`, `rsp_port`, `err` = 0 and `rsp_data` = 0.
  - A request in flight is discarded; the client re-requests.

## Timing
- Grant in cycle 0 (IDLE), select in cycle 1 (SEL), `rsp_valid` from cycle 2 onward.
- Minimum latency from request to valid response: 2 cycles.
- Peak throughput: one read per 3 cycles, reached when `rsp_ready` is held high.
- Read-during-write: a write hitting the selected register at the SEL edge does not affect the captured data. The controller returns the pre-write value, because bank registers update on the same edge.
- `rsp_ready` while `rsp_valid` = 0 is ignored.
- Back-pressure: RESP is held indefinitely while `rsp_ready` = 0; requesters remain stalled (no grant).
- Request withdrawal: a request dropped before its grant is never serviced. The interface rule forbids dropping a request, but the controller must not hang if it happens.

## Structure
- `reg_read_pkg` holds:
  - the state enum (IDLE/SEL/RESP);
  - the port encoding constants PORT_A = 0 and PORT_B = 1;
  - the default WIDTH = 10.
- One sub-module, `rr_arbiter_2`:
  - inputs: two requests plus an enable (state == IDLE);
  - outputs: two grants and the winner index;
  - owns the priority pointer with its asynchronous active-low reset.
- Top level holds the FSM, the address/port latches, the one-hot decode, the slice mux and the response registers.

## Test plan
- **Port A read:** reset; preload reg 5 = 10'h2A5; `a_req` with `a_addr` = 5 → `a_gnt` in cycle 0, `chosen` = 8'b0010_0000 in cycle 1, `rsp_valid` = 1 with `rsp_data` = 10'h2A5, `rsp_port` = 0, `err` = 0 in cycle 2.
- **Contention:** `a_req` (addr 1, value 10'h001) and `b_req` (addr 2, value 10'h3FF) held from reset, `rsp_ready` = 1 → responses in order A (10'h001), B (10'h3FF), A, B; each grant is 3 cycles apart.
- **Back-pressure:** `rsp_ready` = 0 for 5 cycles in RESP → `rsp_valid`, `rsp_data` and `rsp_port` stable throughout; no grant while `b_req` is pending; B is granted in the cycle after the handshake completes.
- **Out of range:** `NREG` = 6, `a_addr` = 7 → `chosen` = 0 in SEL; response has `rsp_data` = 0 and `err` = 1.
- **Read-during-write:** reg 3 = 10'h100; write 10'h200 to reg 3 on the SEL edge of a read of reg 3 → response is 10'h100; an immediate re-read returns 10'h200.
- **Reset mid-operation:** assert `rst` low during SEL, then during RESP → all outputs are 0 asynchronously; after release, the pointer is at A and a new read completes normally.
